multicycle_ctrl: RTL and testbench

//  Multicycle sequencer for the Minisys datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/minisys_pkg.sv | 75 +++++++
 rtl/ctrl_decode.sv | 38 +++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// Shared constants and types for the Minisys multicycle controller:
// instruction opcodes, R-type function codes, sequencer states and the
// instruction-class record produced by the decoder.
package minisys_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // Encodings 5..7 are unused and recover to FETCH.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Exactly one field is set for any opcode/funct pair.
   typedef struct packed {
      logic r_type;
      logic i_alu;
      logic lw;
      logic sw;
      logic branch;
      logic nbranch;
      logic j;
      logic jal;
      logic jr;
      logic illegal;
   } instr_class_t;

   // R-type function codes that perform an ALU operation (jr excluded).
   function automatic logic is_alu_funct(input logic [5:0] funct);
      logic hit;
      case (funct)
         FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
         FN_XOR, FN_NOR, FN_SLT, FN_SLTU: hit = 1'b1;
         default:                         hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: turns opcode/funct into a one-hot
// class record plus the static register-destination and ALU-operand selects.
module ctrl_decode
   import minisys_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t cls,
   output logic         reg_dst,
   output logic         alu_src
);

   // Classify the instruction; anything not recognised is flagged illegal.
   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_JR)           cls.jr      = 1'b1;
            else if (is_alu_funct(funct)) cls.r_type  = 1'b1;
            else                          cls.illegal = 1'b1;
         end
         OP_J:    cls.j       = 1'b1;
         OP_JAL:  cls.jal     = 1'b1;
         OP_BEQ:  cls.branch  = 1'b1;
         OP_BNE:  cls.nbranch = 1'b1;
         OP_LW:   cls.lw      = 1'b1;
         OP_SW:   cls.sw      = 1'b1;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls.i_alu = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

   // R-type ALU ops write rd; immediates and load/store addresses use the extended immediate.
   assign reg_dst = cls.r_type;
   assign alu_src = cls.i_alu | cls.lw | cls.sw;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the Minisys datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, gates the write/access strobes by state
// and waits in MEM for the memory/IO slave with a bounded timeout.
module multicycle_ctrl
   import minisys_pkg::*;
#(
   parameter int          MEM_TIMEOUT = 255,
   parameter logic [21:0] IO_BASE_HI  = 22'h3FFFFF
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [21:0] alu_addr_hi,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        jal,
   output logic        memoriotoreg,
   output logic        alu_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        io_read,
   output logic        io_write,
   output logic [2:0]  state,
   output logic        illegal_op,
   output logic        bus_err
);

   localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_cnt;
   instr_class_t     cls;
   logic             dec_reg_dst;
   logic             dec_alu_src;
   logic             is_io;
   logic             mem_timeout;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .cls     (cls),
      .reg_dst (dec_reg_dst),
      .alu_src (dec_alu_src)
   );

   // The address high bits select IO space; the last allowed MEM cycle without an ack aborts.
   assign is_io       = (alu_addr_hi == IO_BASE_HI);
   assign mem_timeout = (wait_cnt == CNT_LAST) && !mem_ready;
   assign state       = state_q;

   // State register; reset aborts whatever instruction is in flight.
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // MEM wait counter: counts while staying in MEM, clears on every exit and on reset.
   always_ff @(posedge clock) begin
      if (reset)                                      wait_cnt <= '0;
      else if (state_q == S_MEM && state_d == S_MEM) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                            wait_cnt <= '0;
   end

   // Next-state and output decode; reset forces every output low in its cycle.
   always_comb begin
      state_d      = S_FETCH;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      io_read      = 1'b0;
      io_write     = 1'b0;
      illegal_op   = 1'b0;
      bus_err      = 1'b0;
      reg_dst      = dec_reg_dst;
      alu_src      = dec_alu_src;
      jal          = cls.jal;
      memoriotoreg = cls.lw;

      case (state_q)
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            if (cls.illegal) begin
               illegal_op = 1'b1;
            end else if (cls.j) begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
            end else if (cls.jr) begin
               pc_write = 1'b1;
               pc_src   = 2'd3;
            end else if (cls.jal) begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
               state_d  = S_WB;
            end else begin
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls.branch || cls.nbranch) begin
               if ((cls.branch && zero) || (cls.nbranch && !zero)) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd1;
               end
            end else if (cls.lw || cls.sw) begin
               state_d = S_MEM;
            end else if (cls.r_type || cls.i_alu) begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_read  = cls.lw && !is_io;
            io_read   = cls.lw &&  is_io;
            mem_write = cls.sw && !is_io;
            io_write  = cls.sw &&  is_io;
            if (mem_ready) begin
               state_d = cls.lw ? S_WB : S_FETCH;
            end else if (mem_timeout) begin
               bus_err = 1'b1;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (reset) begin
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         pc_src       = 2'd0;
         reg_write    = 1'b0;
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         io_read      = 1'b0;
         io_write     = 1'b0;
         illegal_op   = 1'b0;
         bus_err      = 1'b0;
         reg_dst      = 1'b0;
         alu_src      = 1'b0;
         jal          = 1'b0;
         memoriotoreg = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// the per-cycle output trace the sequencing rules demand, then played against
// the DUT while one compare process checks every cycle.
module tb_multicycle_ctrl;

   localparam int          TO    = 4;
   localparam logic [21:0] IO_HI = 22'h3FFFFF;

   localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4;
   localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  opcode, funct;
   logic [21:0] alu_addr_hi;
   logic        zero, mem_ready;
   logic        ir_write, pc_write, reg_write, reg_dst, jal, memoriotoreg, alu_src;
   logic        mem_read, mem_write, io_read, io_write, illegal_op, bus_err;
   logic [1:0]  pc_src;
   logic [2:0]  state;

   typedef struct packed {
      logic [2:0] st;
      logic       st_dc;
      logic       ir_w;
      logic       pc_w;
      logic [1:0] pc_src;
      logic       reg_w;
      logic       mrd;
      logic       mwr;
      logic       ird;
      logic       iwr;
      logic       ill;
      logic       berr;
      logic       rdy;
      logic       rst;
   } step_t;

   step_t trace[$];
   step_t exp;
   bit    exp_valid = 1'b0;
   int    checks = 0, errors = 0;
   int    n_regw = 0, n_berr = 0, n_ill = 0, n_mrd = 0, n_iwr = 0, n_pcw = 0;

   logic [5:0] ops    [16] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23,
                               6'h2b, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f, 6'h3f, 6'h11};
   logic [5:0] r_fns  [17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .IO_BASE_HI(IO_HI)) dut (
      .clock        (clock),
      .reset        (reset),
      .opcode       (opcode),
      .funct        (funct),
      .alu_addr_hi  (alu_addr_hi),
      .zero         (zero),
      .mem_ready    (mem_ready),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .reg_write    (reg_write),
      .reg_dst      (reg_dst),
      .jal          (jal),
      .memoriotoreg (memoriotoreg),
      .alu_src      (alu_src),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .io_read      (io_read),
      .io_write     (io_write),
      .state        (state),
      .illegal_op   (illegal_op),
      .bus_err      (bus_err)
   );

   always #5 clock = ~clock;

   function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
      int k;
      k = K_ILL;
      if (op == 6'h00) begin
         if (fn == 6'h08) k = K_JR;
         else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                             [6'h20:6'h27], 6'h2a, 6'h2b}) k = K_R;
      end else if (op == 6'h02) k = K_J;
      else if (op == 6'h03) k = K_JAL;
      else if (op == 6'h04) k = K_BEQ;
      else if (op == 6'h05) k = K_BNE;
      else if (op == 6'h23) k = K_LW;
      else if (op == 6'h2b) k = K_SW;
      else if (op >= 6'h08 && op <= 6'h0f) k = K_I;
      return k;
   endfunction

   // {reg_dst, alu_src, jal, memoriotoreg} as a pure function of the instruction.
   function automatic logic [3:0] statics(input logic [5:0] op, input logic [5:0] fn);
      int k;
      k = kind(op, fn);
      return {k == K_R, (k == K_I) || (k == K_LW) || (k == K_SW), k == K_JAL, k == K_LW};
   endfunction

   function automatic step_t mk(input logic [2:0] st);
      step_t s;
      s     = '0;
      s.st  = st;
      s.rdy = 1'($urandom);
      return s;
   endfunction

   // w = MEM cycle index at which mem_ready arrives; w >= TO means it never does.
   function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int w, input logic io);
      step_t s;
      int    k, n;
      k = kind(op, fn);
      s = mk(3'd0); s.ir_w = 1'b1; s.pc_w = 1'b1; trace.push_back(s);
      s = mk(3'd1);
      case (k)
         K_ILL: begin s.ill = 1'b1; trace.push_back(s); end
         K_J, K_JR: begin
            s.pc_w = 1'b1; s.pc_src = (k == K_J) ? 2'd2 : 2'd3; trace.push_back(s);
         end
         K_JAL: begin
            s.pc_w = 1'b1; s.pc_src = 2'd2; trace.push_back(s);
            s = mk(3'd4); s.reg_w = 1'b1; trace.push_back(s);
         end
         K_BEQ, K_BNE: begin
            trace.push_back(s);
            s = mk(3'd2);
            if ((k == K_BEQ) ? z : !z) begin s.pc_w = 1'b1; s.pc_src = 2'd1; end
            trace.push_back(s);
         end
         K_R, K_I: begin
            trace.push_back(s);
            trace.push_back(mk(3'd2));
            s = mk(3'd4); s.reg_w = 1'b1; trace.push_back(s);
         end
         default: begin
            trace.push_back(s);
            trace.push_back(mk(3'd2));
            n = (w < TO) ? w + 1 : TO;
            for (int i = 0; i < n; i++) begin
               s = mk(3'd3);
               s.rdy = (i == w);
               if (k == K_LW) begin s.ird = io; s.mrd = !io; end
               else           begin s.iwr = io; s.mwr = !io; end
               if (w >= TO && i == n - 1) s.berr = 1'b1;
               trace.push_back(s);
            end
            if (k == K_LW && w < TO) begin
               s = mk(3'd4); s.reg_w = 1'b1; trace.push_back(s);
            end
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic play(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [21:0] addr);
      opcode = op; funct = fn; zero = z; alu_addr_hi = addr;
      foreach (trace[i]) begin
         mem_ready = trace[i].rdy;
         reset     = trace[i].rst;
         exp       = trace[i];
         exp_valid = 1'b1;
         @(posedge clock);
         #1;
      end
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int w, input logic [21:0] addr, output int len);
      trace.delete();
      build(op, fn, z, w, addr == IO_HI);
      len = trace.size();
      play(op, fn, z, addr);
   endtask

   // Per-cycle comparison of every DUT output against the expected trace step.
   always @(negedge clock) begin
      logic [3:0] sx;
      if (exp_valid) begin
         sx = exp.rst ? 4'd0 : statics(opcode, funct);
         if (!exp.st_dc) chk("state", 32'(state), 32'(exp.st));
         chk("ir_write",     32'(ir_write),     32'(exp.ir_w));
         chk("pc_write",     32'(pc_write),     32'(exp.pc_w));
         chk("pc_src",       32'(pc_src),       32'(exp.pc_src));
         chk("reg_write",    32'(reg_write),    32'(exp.reg_w));
         chk("mem_read",     32'(mem_read),     32'(exp.mrd));
         chk("mem_write",    32'(mem_write),    32'(exp.mwr));
         chk("io_read",      32'(io_read),      32'(exp.ird));
         chk("io_write",     32'(io_write),     32'(exp.iwr));
         chk("illegal_op",   32'(illegal_op),   32'(exp.ill));
         chk("bus_err",      32'(bus_err),      32'(exp.berr));
         chk("reg_dst",      32'(reg_dst),      32'(sx[3]));
         chk("alu_src",      32'(alu_src),      32'(sx[2]));
         chk("jal",          32'(jal),          32'(sx[1]));
         chk("memoriotoreg", 32'(memoriotoreg), 32'(sx[0]));
         n_regw = n_regw + int'(reg_write);
         n_berr = n_berr + int'(bus_err);
         n_ill  = n_ill  + int'(illegal_op);
         n_mrd  = n_mrd  + int'(mem_read);
         n_iwr  = n_iwr  + int'(io_write);
         n_pcw  = n_pcw  + int'(pc_write);
      end
   end

   initial begin
      int    len, b0, b1, b2;
      step_t s;
      logic [5:0]  op, fn;
      logic [21:0] addr;

      reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
      mem_ready = 1'b0; alu_addr_hi = '0;
      @(posedge clock);
      #1;

      // Reset held: outputs all low, state at FETCH.
      trace.delete();
      s = mk(3'd0); s.st_dc = 1'b1; s.rst = 1'b1; trace.push_back(s);
      s = mk(3'd0); s.rst = 1'b1; trace.push_back(s);
      play(6'h00, 6'h20, 1'b0, 22'h0);

      // add: 4 cycles, one register write.
      b0 = n_regw;
      run(6'h00, 6'h20, 1'b0, 0, 22'h0, len);
      chk("add_len", 32'(len), 32'd4);
      chk("add_regw", 32'(n_regw - b0), 32'd1);

      // lw to RAM, ack after 3 waits: 8 cycles, 4 mem_read cycles, one write-back.
      b0 = n_regw; b1 = n_mrd;
      run(6'h23, 6'h00, 1'b0, 3, 22'h0, len);
      chk("lw_len", 32'(len), 32'd8);
      chk("lw_mrd", 32'(n_mrd - b1), 32'd4);
      chk("lw_regw", 32'(n_regw - b0), 32'd1);

      // sw to IO, immediate ack: 4 cycles, single io_write, no write-back.
      b0 = n_regw; b1 = n_iwr;
      run(6'h2b, 6'h00, 1'b0, 0, IO_HI, len);
      chk("sw_len", 32'(len), 32'd4);
      chk("sw_iwr", 32'(n_iwr - b1), 32'd1);
      chk("sw_regw", 32'(n_regw - b0), 32'd0);

      // beq taken / not taken.
      b0 = n_pcw;
      run(6'h04, 6'h00, 1'b1, 0, 22'h0, len);
      chk("beq_t_len", 32'(len), 32'd3);
      chk("beq_t_pcw", 32'(n_pcw - b0), 32'd2);
      b0 = n_pcw;
      run(6'h04, 6'h00, 1'b0, 0, 22'h0, len);
      chk("beq_nt_pcw", 32'(n_pcw - b0), 32'd1);

      // jal: 3 cycles, writes $31.
      b0 = n_regw;
      run(6'h03, 6'h00, 1'b0, 0, 22'h0, len);
      chk("jal_len", 32'(len), 32'd3);
      chk("jal_regw", 32'(n_regw - b0), 32'd1);

      // lw timeout: bus_err once, no write-back.
      b0 = n_regw; b1 = n_berr;
      run(6'h23, 6'h00, 1'b0, 100, 22'h0, len);
      chk("to_len", 32'(len), 32'd7);
      chk("to_berr", 32'(n_berr - b1), 32'd1);
      chk("to_regw", 32'(n_regw - b0), 32'd0);

      run(6'h02, 6'h00, 1'b0, 0, 22'h0, len);
      chk("j_len", 32'(len), 32'd2);
      run(6'h00, 6'h08, 1'b0, 0, 22'h0, len);
      chk("jr_len", 32'(len), 32'd2);

      // Reset during MEM with mem_read high, ack offered in the reset cycle.
      trace.delete();
      build(6'h23, 6'h00, 1'b0, 100, 1'b0);
      while (trace.size() > 4) void'(trace.pop_back());
      s = mk(3'd0); s.st_dc = 1'b1; s.rst = 1'b1; s.rdy = 1'b1; trace.push_back(s);
      s = mk(3'd0); s.rst = 1'b1; trace.push_back(s);
      b1 = n_mrd; b2 = n_regw;
      play(6'h23, 6'h00, 1'b0, 22'h0);
      chk("rst_mrd", 32'(n_mrd - b1), 32'd1);
      chk("rst_regw", 32'(n_regw - b2), 32'd0);

      // Undefined opcode after reset.
      b0 = n_ill;
      run(6'h3f, 6'h00, 1'b0, 0, 22'h0, len);
      chk("ill_len", 32'(len), 32'd2);
      chk("ill_pulse", 32'(n_ill - b0), 32'd1);

      // Random instruction stream.
      for (int n = 0; n < 300; n++) begin
         op = ops[$urandom_range(0, 15)];
         fn = $urandom_range(0, 1) ? r_fns[$urandom_range(0, 16)] : 6'($urandom);
         addr = $urandom_range(0, 1) ? IO_HI : 22'($urandom);
         run(op, fn, 1'($urandom), int'($urandom_range(0, 6)), addr, len);
      end

      exp_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
